// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the N-way system-control coprocessor.
//   - CP0 register numbers, ExcCodes (including the NONE/ERET pseudo-codes),
//     Status/Cause bit positions and flush-enable levels.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // ExcCodes; NONE and ERET are pipeline pseudo-codes, never stored in Cause
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  // Status bit positions
  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_IM_LO = 8;
  localparam int unsigned ST_IM_HI = 15;

  // Cause bit positions
  localparam int unsigned CA_BD     = 31;
  localparam int unsigned CA_TI     = 30;
  localparam int unsigned CA_IP_LO  = 8;
  localparam int unsigned CA_IP_HI  = 15;
  localparam int unsigned CA_EXC_LO = 2;
  localparam int unsigned CA_EXC_HI = 6;

  // Flush-enable levels
  localparam logic FLUSH_EN  = 1'b1;
  localparam logic FLUSH_DIS = 1'b0;

  // Assemble the architectural Cause word from its stored fields.
  function automatic logic [31:0] cause_pack(input logic       bd,
                                             input logic       ti,
                                             input logic [7:0] ip,
                                             input logic [4:0] exccode);
    logic [31:0] c;
    c                       = '0;
    c[CA_BD]                = bd;
    c[CA_TI]                = ti;
    c[CA_IP_HI:CA_IP_LO]    = ip;
    c[CA_EXC_HI:CA_EXC_LO]  = exccode;
    return c;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with programmable prescaler.
//   clk_i, rst_ni         clock, async active-low reset
//   count_we_i/_wdata_i   load Count (also restarts the prescaler)
//   compare_we_i/_wdata_i load Compare (also clears TI)
//   count_o, compare_o    current register values
//   ti_o                  timer interrupt flag (Cause.TI)
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        count_we_i,
  input  logic [31:0] count_wdata_i,
  input  logic        compare_we_i,
  input  logic [31:0] compare_wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam logic [4:0] PRESC_MAX = 5'(COUNT_DIV - 1);

  logic [4:0]  presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic [31:0] count_inc;

  assign count_inc = count_q + 32'd1;

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      // A software load never raises TI by itself
      count_d = count_wdata_i;
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      count_d = count_inc;
      if (count_inc == compare_q) ti_d = 1'b1;
    end else begin
      presc_d = presc_q + 5'd1;
    end
    // Compare write takes priority over a coincident match
    if (compare_we_i) begin
      compare_d = compare_wdata_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_nway.sv
// cp0_nway: system-control coprocessor for the N-way superscalar core.
//   clk, rst_            clock, async active-low reset
//   ex_cp0_re/raddr/rdata   per-way MFC0 reads at EX (combinational)
//   wb_cp0_we/waddr/wdata   per-way MTC0 writes from WB, wb_pc their PCs
//   int_i                   external level-sensitive interrupts
//   ex_exc_code/pc/bad_vaddr/in_delay  per-way exception reports from EX
//   exc_flush_all           flush request (combinational), exc_flush_icache one cycle later
//   cp0_if_excaddr          IF redirect target while flushing
//   timer_int               Cause.TI
module cp0_nway
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_WAYS   = 2,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0000_FF01
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NUM_WAYS-1:0]    ex_cp0_re,
  input  logic [5*NUM_WAYS-1:0]  ex_cp0_raddr,
  output logic [32*NUM_WAYS-1:0] ex_cp0_rdata,
  input  logic [NUM_WAYS-1:0]    wb_cp0_we,
  input  logic [5*NUM_WAYS-1:0]  wb_cp0_waddr,
  input  logic [32*NUM_WAYS-1:0] wb_cp0_wdata,
  input  logic [32*NUM_WAYS-1:0] wb_pc,
  input  logic [5:0]             int_i,
  input  logic [5*NUM_WAYS-1:0]  ex_exc_code,
  input  logic [32*NUM_WAYS-1:0] ex_exc_pc,
  input  logic [32*NUM_WAYS-1:0] ex_bad_vaddr,
  input  logic [NUM_WAYS-1:0]    ex_in_delay,
  output logic                   exc_flush_all,
  output logic                   exc_flush_icache,
  output logic [31:0]            cp0_if_excaddr,
  output logic                   timer_int
);

  // Architectural state
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q;
  logic [31:0] soft_epc_q, soft_epc_d;
  logic        flush_q;

  // Timer interface
  logic [31:0] count, compare;
  logic        ti;

  logic [7:0]  cause_ip;
  logic [31:0] cause_val;
  logic        int_pending;
  logic        soft_only;

  // IP7 follows TI in the same cycle so the timer interrupt is visible at once
  assign cause_ip    = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
  assign cause_val   = cause_pack(bd_q, ti, cause_ip, exccode_q);
  assign int_pending = (|(status_q[ST_IM_HI:ST_IM_LO] & cause_ip)) &&
                       !status_q[ST_EXL] && status_q[ST_IE];
  // Only software IP bits contribute to the pending interrupt
  assign soft_only   = ~|(status_q[ST_IM_HI:ST_IM_LO+2] & cause_ip[7:2]);

  // Winner: lowest-index way reporting a code; interrupt rides on way 0
  logic [4:0]  way_code [NUM_WAYS];
  logic        win_found;
  logic [4:0]  win_code;
  logic [31:0] win_pc, win_bad;
  logic        win_delay;

  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) way_code[i] = ex_exc_code[5*i +: 5];
    if (int_pending) way_code[0] = EXC_INT;
  end

  always_comb begin
    win_found = 1'b0;
    win_code  = EXC_NONE;
    win_pc    = '0;
    win_bad   = '0;
    win_delay = 1'b0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_code[i] != EXC_NONE) begin
        win_found = 1'b1;
        win_code  = way_code[i];
        win_pc    = ex_exc_pc[32*i +: 32];
        win_bad   = ex_bad_vaddr[32*i +: 32];
        win_delay = ex_in_delay[i];
      end
    end
  end

  // MTC0 decode; later (younger) ways overwrite earlier ones
  logic        wr_badv, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] badv_wdata, count_wdata, compare_wdata, status_wdata, cause_wdata, epc_wdata;
  logic [31:0] cause_wpc;

  always_comb begin
    wr_badv       = 1'b0;
    wr_count      = 1'b0;
    wr_compare    = 1'b0;
    wr_status     = 1'b0;
    wr_cause      = 1'b0;
    wr_epc        = 1'b0;
    badv_wdata    = '0;
    count_wdata   = '0;
    compare_wdata = '0;
    status_wdata  = '0;
    cause_wdata   = '0;
    epc_wdata     = '0;
    cause_wpc     = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (wb_cp0_we[i]) begin
        case (wb_cp0_waddr[5*i +: 5])
          CP0_BADVADDR: begin wr_badv    = 1'b1; badv_wdata    = wb_cp0_wdata[32*i +: 32]; end
          CP0_COUNT:    begin wr_count   = 1'b1; count_wdata   = wb_cp0_wdata[32*i +: 32]; end
          CP0_COMPARE:  begin wr_compare = 1'b1; compare_wdata = wb_cp0_wdata[32*i +: 32]; end
          CP0_STATUS:   begin wr_status  = 1'b1; status_wdata  = wb_cp0_wdata[32*i +: 32]; end
          CP0_CAUSE: begin
            wr_cause    = 1'b1;
            cause_wdata = wb_cp0_wdata[32*i +: 32];
            cause_wpc   = wb_pc[32*i +: 32];
          end
          CP0_EPC:      begin wr_epc     = 1'b1; epc_wdata     = wb_cp0_wdata[32*i +: 32]; end
          default: ;
        endcase
      end
    end
  end

  // ERET target sees a same-cycle MTC0 EPC even though that write is dropped
  logic [31:0] epc_eff;
  logic        eret_ok;
  assign epc_eff = wr_epc ? epc_wdata : epc_q;
  assign eret_ok = (epc_eff[1:0] == 2'b00);

  always_comb begin
    badvaddr_d = badvaddr_q;
    status_d   = status_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    soft_epc_d = soft_epc_q;
    if (win_found) begin
      if (win_code == EXC_ERET) begin
        if (eret_ok) begin
          status_d[ST_EXL] = 1'b0;
        end else begin
          exccode_d        = EXC_ADEL;
          badvaddr_d       = epc_eff;
          status_d[ST_EXL] = 1'b1;
        end
      end else begin
        if (!status_q[ST_EXL]) begin
          if (win_code == EXC_INT && soft_only) begin
            epc_d = soft_epc_q;
            bd_d  = 1'b0;
          end else if (win_delay) begin
            epc_d = win_pc - 32'd4;
            bd_d  = 1'b1;
          end else begin
            epc_d = win_pc;
            bd_d  = 1'b0;
          end
        end
        status_d[ST_EXL] = 1'b1;
        exccode_d        = win_code;
        if (win_code == EXC_ADEL || win_code == EXC_ADES) badvaddr_d = win_bad;
      end
    end else begin
      if (wr_badv)   badvaddr_d = badv_wdata;
      if (wr_status) status_d   = status_wdata;
      if (wr_epc)    epc_d      = epc_wdata;
      if (wr_cause) begin
        ip_sw_d    = cause_wdata[CA_IP_LO+1:CA_IP_LO];
        soft_epc_d = cause_wpc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      badvaddr_q <= '0;
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      soft_epc_q <= '0;
      flush_q    <= FLUSH_DIS;
    end else begin
      badvaddr_q <= badvaddr_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= int_i;
      soft_epc_q <= soft_epc_d;
      flush_q    <= exc_flush_all;
    end
  end

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk_i           (clk),
    .rst_ni          (rst_),
    .count_we_i      (wr_count & ~win_found),
    .count_wdata_i   (count_wdata),
    .compare_we_i    (wr_compare & ~win_found),
    .compare_wdata_i (compare_wdata),
    .count_o         (count),
    .compare_o       (compare),
    .ti_o            (ti)
  );

  // MFC0 reads: no bypass of same-cycle writes
  logic [31:0] rd_val;
  always_comb begin
    ex_cp0_rdata = '0;
    rd_val       = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      case (ex_cp0_raddr[5*i +: 5])
        CP0_BADVADDR: rd_val = badvaddr_q;
        CP0_COUNT:    rd_val = count;
        CP0_COMPARE:  rd_val = compare;
        CP0_STATUS:   rd_val = status_q;
        CP0_CAUSE:    rd_val = cause_val;
        CP0_EPC:      rd_val = epc_q;
        default:      rd_val = '0;
      endcase
      if (rst_ && ex_cp0_re[i]) ex_cp0_rdata[32*i +: 32] = rd_val;
    end
  end

  assign exc_flush_all    = rst_ ? (win_found ? FLUSH_EN : FLUSH_DIS) : FLUSH_DIS;
  assign exc_flush_icache = flush_q;
  assign cp0_if_excaddr   = (rst_ && win_found) ?
                            ((win_code == EXC_ERET && eret_ok) ? epc_eff : EXC_VECTOR) : 32'h0;
  assign timer_int        = rst_ & ti;

endmodule

// File: doc/cp0_nway.md
Name: cp0_nway

Overview:
- Parametrised next-generation system-control coprocessor for the N-way superscalar core.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Arbitrates exceptions and ERET from NUM_WAYS parallel EX-stage slots, serves MFC0 reads at EX and MTC0 writes from WB.
- New against the dual-issue version: a Count/Compare timer interrupt (Cause.TI, IP7) and a programmable Count prescaler.
- Drives the pipeline flush and the IF redirect address.

Parameters:
- NUM_WAYS, 2, number of issue ways (1..4); way 0 is the oldest instruction.
- COUNT_DIV, 2, core cycles per Count increment (1..16).
- EXC_VECTOR, 32'hBFC0_0380, entry PC for all exceptions and interrupts.
- STATUS_RST, 32'h0000_FF01, Status reset value (IM all set, IE=1, EXL=0).

Ports:
- clk  in  1  core clock, rising edge.
- rst_  in  1  asynchronous active-low reset.
- ex_cp0_re  in  NUM_WAYS  per-way MFC0 read enable.
- ex_cp0_raddr  in  5*NUM_WAYS  per-way CP0 register number.
- ex_cp0_rdata  out  32*NUM_WAYS  per-way read data; 0 when not enabled or the address is unmapped.
- wb_cp0_we  in  NUM_WAYS  per-way MTC0 write enable (one pulse per retired MTC0).
- wb_cp0_waddr  in  5*NUM_WAYS  per-way write register number.
- wb_cp0_wdata  in  32*NUM_WAYS  per-way write data.
- wb_pc  in  32*NUM_WAYS  per-way WB PC.
- int_i  in  6  external hardware interrupts, level sensitive.
- ex_exc_code  in  5*NUM_WAYS  per-way ExcCode; 5'h10 means none, 5'h11 means ERET.
- ex_exc_pc  in  32*NUM_WAYS  per-way faulting PC.
- ex_bad_vaddr  in  32*NUM_WAYS  per-way faulting address for AdEL/AdES.
- ex_in_delay  in  NUM_WAYS  per-way branch-delay-slot flag.
- exc_flush_all  out  1  flush all stages this cycle.
- exc_flush_icache  out  1  exc_flush_all delayed one cycle.
- cp0_if_excaddr  out  32  IF redirect target, valid while exc_flush_all=1.
- timer_int  out  1  mirror of Cause.TI.

Behaviour:
- Reset (asynchronous): BadVAddr=0, Count=0, Compare=32'hFFFF_FFFF, Status=STATUS_RST, Cause=0, EPC=0, prescaler=0, exc_flush_icache=0, soft-interrupt EPC=0.
- Combinational outputs forced to 0 while rst_=0.
- Cause.IP[7:2] is resampled every cycle. IP[6:2]=int_i[4:0]. IP7=int_i[5] | Cause.TI.
- Interrupt pending: (Status[15:8] & Cause[15:8])!=0, Status.EXL=0 and Status.IE=1. A pending interrupt is attached to way 0 with ExcCode 0.
- Winner: the lowest-index way with code != 5'h10. Younger ways are discarded.
  - Delay-slot exception: the slot is way k+1 and its branch is way k. The winner remains the lowest-index way reporting a code.
- exc_flush_all is combinational, asserted when a winner exists.
- Register updates for the winner land on the next rising edge.
- Exception winner, non-ERET:
  - If EXL=0: EPC = pc-4 with Cause.BD=1 when in_delay=1; otherwise EPC = pc with BD=0.
  - Interrupt raised by a software IP write: EPC = the PC of the MTC0 Cause + 4.
  - Always: EXL<=1, Cause.ExcCode<=code.
  - For codes 4/5: BadVAddr<=ex_bad_vaddr of the winner.
  - cp0_if_excaddr=EXC_VECTOR.
- ERET winner:
  - EPC[1:0]=0: EXL<=0 and cp0_if_excaddr=EPC. If the same cycle has an MTC0 to EPC, the bypassed value is used.
  - Otherwise: ExcCode<=4, BadVAddr<=EPC, EXL stays 1, cp0_if_excaddr=EXC_VECTOR.
- MTC0, applied only when there is no winner that cycle:
  - Per register, the highest-index writing way wins (youngest).
  - A write to Compare also clears Cause.TI.
  - Writes to Cause affect only IP[1:0]; all other Cause bits are read-only.
  - Writes to Status take effect on the next cycle.
- Timer:
  - The prescaler counts 0..COUNT_DIV-1. Count increments at wrap.
  - Count wraps 32'hFFFF_FFFF to 0.
  - Cause.TI sets on the edge where the incremented Count equals Compare. It stays set until a Compare write.
  - An MTC0 to Count loads Count and resets the prescaler; it does not itself set TI.
  - Simultaneous Compare write and match: the write wins, so TI=0.
- MFC0 read-during-write: returns the old value (no bypass).
- Reset mid-exception: all state returns to reset values immediately; exc_flush_all drops combinationally.

Decomposition:
- Shared package cp0_pkg holds:
  - register numbers: BADVADDR=8, COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14;
  - ExcCodes: INT=0, ADEL=4, ADES=5, SYS=8, RI=10, OV=12, NONE=5'h10, ERET=5'h11;
  - Status/Cause bit positions: IE=0, EXL=1, IM=15:8, BD=31, TI=30, IP=15:8, ExcCode=6:2;
  - the flush-enable constants.
- Sub-module cp0_timer holds the prescaler, Count, Compare, TI set/clear and the load interface.
- Arbitration and the register file stay in cp0_nway.

Test Plan:
- Way 0 code 5'h10, way 1 code SYS (8), pc 0x8000_1004, not in delay slot -> flush=1, excaddr=0xBFC0_0380; next cycle EPC=0x8000_1004, ExcCode=8, EXL=1.
- Way 0 RI in delay slot, pc 0x8000_2004, way 1 OV -> way 0 wins; EPC=0x8000_2000, BD=1, ExcCode=10.
- MTC0 Compare=20, COUNT_DIV=2, Count=0 -> TI and IP7 assert on the edge where Count becomes 20 (~40 cycles); with IM7=1, IE=1 the interrupt flushes to 0xBFC0_0380; MTC0 Compare clears TI.
- Same-cycle MTC0 to Status from way 0 (0x1) and way 1 (0x0000_FF03) -> Status=0x0000_FF03; same cycle with a winning exception -> no write.
- ERET with EPC=0x8000_3002 -> flush to 0xBFC0_0380, ExcCode=4, BadVAddr=0x8000_3002; ERET with EPC=0x8000_3000 -> excaddr=0x8000_3000, EXL=0.
- Assert rst_ low mid-cycle during flush -> flush and all outputs go to 0 immediately; Count=0, Compare=0xFFFF_FFFF.
